mux_4way_16: RTL and testbench
==============================

// Module: mux_4way_16
// PURPOSE
//  16-bit, 4-input multiplexer selected by two independent select bits (S2 = MSB, S1 = LSB).
//  Primary output O is purely combinational: zero latency, no clock dependence.
//  A registered copy O_q, one clock later, is provided for timing-closed downstream consumers.
//  Used as a generic datapath steering leaf (bus/ALU operand selection).
// PARAMETERS
//  WIDTH      16   data width of I1..I4, O, O_q
//  RESET_VAL  '0   value loaded into O_q while rst is high
// PORTS
//  clk  input   1      single clock; O_q samples on rising edge
//  rst  input   1      asynchronous, active-high reset; affects O_q only
//  O    output  WIDTH  combinational mux output
//  S1   input   1      select LSB
//  S2   input   1      select MSB
//  I1   input   WIDTH  data in, chosen when {S2,S1}=2'b00
//  I2   input   WIDTH  data in, chosen when {S2,S1}=2'b01
//  I3   input   WIDTH  data in, chosen when {S2,S1}=2'b10
//  I4   input   WIDTH  data in, chosen when {S2,S1}=2'b11
//  O_q  output  WIDTH  registered O
//  Port order for positional instantiation: O, S1, S2, I1, I2, I3, I4, clk, rst, O_q
// BEHAVIOUR
//  - sel = {S2,S1}; O = I1 / I2 / I3 / I4 for sel = 0 / 1 / 2 / 3. Bitwise, no arithmetic.
//  - O reacts to any change of S1, S2 or I1..I4 in the same delta; no latch, no clock.
//  - S1 or S2 X/Z: O is X on every bit where the candidate inputs differ. Never
//    silently default to I1.
//  - O_q: rst high -> O_q = RESET_VAL immediately, regardless of clk.
//    Otherwise O_q <= O on each posedge clk. Latency exactly 1 cycle.
//  - Reset release: first posedge with rst low loads the current O.
//    rst asserted mid-stream clears O_q at once; O is unaffected.
//  - Select change and data change in the same cycle: O_q captures the O settled
//    before the edge, i.e. new select applied to new data.
//  - Full-range data (16'h0000..16'hFFFF) passes unmodified; no width truncation or
//    sign handling.
// STRUCTURE
//  - Shared package mux_pkg:
//    - SEL_I1..SEL_I4 = 2'd0..2'd3
//    - DATA_W = 16
//  - One natural sub-module, mux_2way_16 (O, S, A, B: O = S ? B : A), built as a 16-bit
//    AND/OR/NOT gate array. It is instantiated 3 times as a tree:
//    - level 0 on S1: I1/I2 and I3/I4
//    - level 1 on S2
//  - O_q is a WIDTH-bit async-reset flop bank in the top level; no FSM.
// TESTING
//  1. Exhaustive select with distinct data:
//     I1=16'h1111, I2=16'h2222, I3=16'h3333, I4=16'h4444; sel 00,01,10,11
//     -> O = 1111, 2222, 3333, 4444.
//  2. Bit isolation: I1=16'hFFFF, others 16'h0000; sel=00 -> O=FFFF; sel=01/10/11 -> O=0000.
//     Repeat walking-one across all 16 bits of each input.
//  3. Randomised sweep, >=10k vectors: random I1..I4 and S1/S2, checked against a
//     golden case-statement model every 10 time units.
//  4. Register path: rst=1 -> O_q=0000 with no clk edge.
//     Release rst, sel=10, I3=16'hA5A5 -> O_q=A5A5 one posedge later, not before.
//  5. Async reset mid-stream: O_q=16'hBEEF, assert rst between edges -> O_q=0000 at once.
//     O still tracks inputs.
//  6. Same-cycle change: flip S2 and I4 together before an edge -> O_q equals the new
//     selected value; O updates with zero clock latency.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants for the 4-way mux family: data width and select encodings.
package mux_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    SEL_I1 = 2'd0,
    SEL_I2 = 2'd1,
    SEL_I3 = 2'd2,
    SEL_I4 = 2'd3
  } sel_e;

endpackage

// File: rtl/mux_2way_16.sv
// 2-input gate-level mux leaf: O = S ? B : A, built from AND/OR/NOT.
module mux_2way_16
  import mux_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  output logic [WIDTH-1:0] O,
  input  logic             S,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B
);

  logic [WIDTH-1:0] s_vec;

  assign s_vec = {WIDTH{S}};

  // Consensus term A&B keeps bits known when S is X/Z but both candidates agree.
  assign O = (A & ~s_vec) | (B & s_vec) | (A & B);

endmodule

// File: rtl/mux_4way_16.sv
// 16-bit 4:1 mux as a tree of 2:1 leaves, plus a one-cycle registered copy of the output.
module mux_4way_16
  import mux_pkg::*;
#(
  parameter int               WIDTH     = DATA_W,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  output logic [WIDTH-1:0] O,
  input  logic             S1,
  input  logic             S2,
  input  logic [WIDTH-1:0] I1,
  input  logic [WIDTH-1:0] I2,
  input  logic [WIDTH-1:0] I3,
  input  logic [WIDTH-1:0] I4,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] O_q
);

  logic [WIDTH-1:0] lo_pair;
  logic [WIDTH-1:0] hi_pair;

  mux_2way_16 #(.WIDTH(WIDTH)) u_mux_lo (
    .O (lo_pair),
    .S (S1),
    .A (I1),
    .B (I2)
  );

  mux_2way_16 #(.WIDTH(WIDTH)) u_mux_hi (
    .O (hi_pair),
    .S (S1),
    .A (I3),
    .B (I4)
  );

  mux_2way_16 #(.WIDTH(WIDTH)) u_mux_out (
    .O (O),
    .S (S2),
    .A (lo_pair),
    .B (hi_pair)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      O_q <= RESET_VAL;
    end else begin
      O_q <= O;
    end
  end

endmodule

// File: tb/tb_mux_4way_16.sv
// Self-checking bench for mux_4way_16: directed steps plus a randomized sweep against an array-indexed model.
module tb_mux_4way_16;

  logic        clk;
  logic        rst;
  logic        s1;
  logic        s2;
  logic [15:0] i1, i2, i3, i4;
  logic [15:0] o;
  logic [15:0] o_q;

  int total;
  int bad;

  logic [15:0] data [4];
  logic [15:0] exp_q;
  logic [15:0] one_hot;

  mux_4way_16 dut (
    .O   (o),
    .S1  (s1),
    .S2  (s2),
    .I1  (i1),
    .I2  (i2),
    .I3  (i3),
    .I4  (i4),
    .clk (clk),
    .rst (rst),
    .O_q (o_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: the selected input is simply the data array indexed by {S2,S1}.
  function automatic logic [15:0] model(input logic [1:0] sel);
    return data[sel];
  endfunction

  task automatic apply(input logic [1:0] sel, input logic [15:0] a, b, c, d);
    data[0] = a; data[1] = b; data[2] = c; data[3] = d;
    i1 = a; i2 = b; i3 = c; i4 = d;
    s2 = sel[1];
    s1 = sel[0];
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    apply(2'd0, 16'h0, 16'h0, 16'h0, 16'h0);

    // Reset value is present before any clock edge.
    #2;
    check("reset_no_edge", o_q, 16'h0000);

    // Exhaustive select with distinct data.
    for (int sel = 0; sel < 4; sel++) begin
      apply(sel[1:0], 16'h1111, 16'h2222, 16'h3333, 16'h4444);
      #1;
      check("distinct_sel", o, 16'h1111 * 16'(sel + 1));
    end

    // Bit isolation: walking one on each input, every select.
    for (int inp = 0; inp < 4; inp++) begin
      for (int b = 0; b < 16; b++) begin
        one_hot = 16'h0001 << b;
        for (int sel = 0; sel < 4; sel++) begin
          apply(sel[1:0],
                (inp == 0) ? one_hot : 16'h0,
                (inp == 1) ? one_hot : 16'h0,
                (inp == 2) ? one_hot : 16'h0,
                (inp == 3) ? one_hot : 16'h0);
          #1;
          check("walk_one", o, (sel == inp) ? one_hot : 16'h0000);
        end
      end
    end
    apply(2'd0, 16'hFFFF, 16'h0, 16'h0, 16'h0);
    #1;
    check("all_ones_i1", o, 16'hFFFF);
    check("reset_hold", o_q, 16'h0000);

    // Register path: release reset, value appears one posedge later, not before.
    @(negedge clk);
    rst = 1'b0;
    apply(2'd2, 16'h0, 16'h0, 16'hA5A5, 16'h0);
    #1;
    check("o_after_release", o, 16'hA5A5);
    check("oq_not_before_edge", o_q, 16'h0000);
    @(posedge clk);
    #1;
    check("oq_one_cycle", o_q, 16'hA5A5);

    // Async reset mid-stream.
    @(negedge clk);
    apply(2'd3, 16'h0, 16'h0, 16'h0, 16'hBEEF);
    @(posedge clk);
    #1;
    check("oq_beef", o_q, 16'hBEEF);
    #2;
    rst = 1'b1;
    #1;
    check("async_clear", o_q, 16'h0000);
    apply(2'd0, 16'h7E57, 16'h0, 16'h0, 16'hBEEF);
    #1;
    check("o_tracks_in_reset", o, 16'h7E57);
    @(negedge clk);
    rst = 1'b0;

    // Same-cycle select and data change.
    apply(2'd2, 16'h0, 16'h0, 16'h1234, 16'h5678);
    @(posedge clk);
    #1;
    check("oq_pre_flip", o_q, 16'h1234);
    @(negedge clk);
    apply(2'd3, 16'h0, 16'h0, 16'h1234, 16'h9ABC);
    #1;
    check("o_flip_zero_latency", o, 16'h9ABC);
    @(posedge clk);
    #1;
    check("oq_flip", o_q, 16'h9ABC);

    // Randomized sweep with occasional reset pulses.
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 31) == 0);
      apply(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
            16'($urandom), 16'($urandom));
      #1;
      check("rand_o", o, model({s2, s1}));
      if (rst) check("rand_async_rst", o_q, 16'h0000);
      exp_q = rst ? 16'h0000 : model({s2, s1});
      @(posedge clk);
      #1;
      check("rand_oq", o_q, exp_q);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
